// File: rtl/fifo_framer_pkg.sv
// Shared types and constants for the FIFO write-side framer.
// Holds the FSM state encoding, default delimiter/escape bytes and the stuffing predicate.
package fifo_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SOF      = 3'd1,
        ST_DATA     = 3'd2,
        ST_ESC2     = 3'd3,
        ST_CHK      = 3'd4,
        ST_CHK_ESC2 = 3'd5,
        ST_EOF      = 3'd6
    } state_t;

    localparam logic [7:0] DEF_SOF_BYTE = 8'h7E;
    localparam logic [7:0] DEF_ESC_BYTE = 8'h7D;
    localparam logic [7:0] DEF_ESC_XOR  = 8'h20;

    // A byte needs stuffing when it collides with either control byte.
    function automatic logic is_special(input logic [7:0] b,
                                        input logic [7:0] sof,
                                        input logic [7:0] esc);
        return (b == sof) || (b == esc);
    endfunction

endpackage

// File: rtl/fifo_wr_framer.sv
// Write-side framer: SOF, stuffed payload, stuffed XOR checksum, EOF into an async FIFO.
// Optional FIFO_WR_GUARD_EN limits writes to one every two cycles to cover the stale full flag.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | no frame open, waiting for s_valid
// SOF      | writing the start delimiter
// DATA     | accepting payload, writing byte or escape prefix
// ESC2     | writing the escaped payload byte held from DATA
// CHK      | writing checksum or its escape prefix
// CHK_ESC2 | writing the escaped checksum byte
// EOF      | writing the end delimiter, bumping frame_cnt
module fifo_wr_framer
    import fifo_framer_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE  = DEF_SOF_BYTE,
    parameter logic [7:0] ESC_BYTE  = DEF_ESC_BYTE,
    parameter logic [7:0] ESC_XOR   = DEF_ESC_XOR,
    parameter int         CNT_WIDTH = 16
) (
    input  logic                 wr_clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [7:0]           s_data,
    input  logic                 s_last,
    output logic                 fifo_wr_en,
    output logic [7:0]           fifo_data,
    input  logic                 fifo_full,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic                 busy
);

    state_t                 state_q;
    state_t                 state_d;
    logic [7:0]             chk_q;
    logic [7:0]             hold_data_q;
    logic                   hold_last_q;
    logic [CNT_WIDTH-1:0]   frame_cnt_q;

    logic                   guard;
    logic                   slot;
    logic                   emits;
    logic [7:0]             emit_data;
    logic                   accept;
    logic                   data_special;
    logic                   chk_special;

`ifdef FIFO_WR_GUARD_EN
    logic guard_q;

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            guard_q <= 1'b0;
        end else begin
            guard_q <= fifo_wr_en;
        end
    end

    assign guard = guard_q;
`else
    assign guard = 1'b0;
`endif

    assign slot         = !fifo_full && !guard;
    assign data_special = is_special(s_data, SOF_BYTE, ESC_BYTE);
    assign chk_special  = is_special(chk_q, SOF_BYTE, ESC_BYTE);
    assign accept       = (state_q == ST_DATA) && s_valid && slot;

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    state_d = ST_SOF;
                end
            end
            ST_SOF: begin
                if (slot) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    if (data_special) begin
                        state_d = ST_ESC2;
                    end else if (s_last) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_ESC2: begin
                if (slot) begin
                    state_d = hold_last_q ? ST_CHK : ST_DATA;
                end
            end
            ST_CHK: begin
                if (slot) begin
                    state_d = chk_special ? ST_CHK_ESC2 : ST_EOF;
                end
            end
            ST_CHK_ESC2: begin
                if (slot) begin
                    state_d = ST_EOF;
                end
            end
            ST_EOF: begin
                if (slot) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        emits     = 1'b0;
        emit_data = 8'h00;
        s_ready   = 1'b0;
        case (state_q)
            ST_SOF: begin
                emits     = 1'b1;
                emit_data = SOF_BYTE;
            end
            ST_DATA: begin
                s_ready   = slot;
                emits     = s_valid;
                emit_data = data_special ? ESC_BYTE : s_data;
            end
            ST_ESC2: begin
                emits     = 1'b1;
                emit_data = hold_data_q;
            end
            ST_CHK: begin
                emits     = 1'b1;
                emit_data = chk_special ? ESC_BYTE : chk_q;
            end
            ST_CHK_ESC2: begin
                emits     = 1'b1;
                emit_data = chk_q ^ ESC_XOR;
            end
            ST_EOF: begin
                emits     = 1'b1;
                emit_data = SOF_BYTE;
            end
            default: begin
                emits     = 1'b0;
                emit_data = 8'h00;
            end
        endcase
    end

    assign fifo_wr_en = emits && slot;
    assign fifo_data  = fifo_wr_en ? emit_data : 8'h00;
    assign busy       = (state_q != ST_IDLE);
    assign frame_cnt  = frame_cnt_q;

    // Checksum covers raw payload bytes; it is cleared while idle so every frame starts fresh.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            chk_q       <= 8'h00;
            hold_data_q <= 8'h00;
            hold_last_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) begin
                chk_q <= 8'h00;
            end else if (accept) begin
                chk_q <= chk_q ^ s_data;
            end
            if (accept && data_special) begin
                hold_data_q <= s_data ^ ESC_XOR;
                hold_last_q <= s_last;
            end
        end
    end

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (state_q == ST_EOF && slot) begin
            frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fifo_wr_framer.sv
// Directed self-checking bench for fifo_wr_framer (frame counter narrowed to 2 bits to reach wrap).
// Timing expectations that depend on FIFO_WR_GUARD_EN are selected with the same macro.
module tb_fifo_wr_framer;

    localparam int CW = 2;

    logic          wr_clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    s_data;
    logic          s_last;
    logic          fifo_wr_en;
    logic [7:0]    fifo_data;
    logic          fifo_full;
    logic [CW-1:0] frame_cnt;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    fifo_wr_framer #(.CNT_WIDTH(CW)) dut (
        .wr_clk     (wr_clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .fifo_full  (fifo_full),
        .frame_cnt  (frame_cnt),
        .busy       (busy)
    );

    always #5 wr_clk = ~wr_clk;

    int cyc = 0;
    always @(posedge wr_clk) cyc <= cyc + 1;

    logic [7:0] wr_q[$];
    int         wr_cyc_q[$];
    int         b2b = 0;
    int         stall_viol = 0;
    logic       prev_wr = 1'b0;

    always @(negedge wr_clk) begin
        if (fifo_wr_en) begin
            wr_q.push_back(fifo_data);
            wr_cyc_q.push_back(cyc);
        end
        if (fifo_wr_en && prev_wr) b2b++;
        if (fifo_full && (fifo_wr_en || (s_valid && s_ready))) stall_viol++;
        prev_wr = fifo_wr_en;
    end

    logic [7:0] pay[$];
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input bit no_last, output int waits, output bit timeout);
        bit acc;
        int budget;
        waits   = 0;
        timeout = 1'b0;
        for (int i = 0; i < pay.size(); i++) begin
            acc    = 1'b0;
            budget = 0;
            s_valid = 1'b1;
            s_data  = pay[i];
            s_last  = !no_last && (i == pay.size() - 1);
            while (!acc && !timeout) begin
                @(negedge wr_clk);
                acc = s_ready;
                if (!acc) waits++;
                @(posedge wr_clk);
                #1;
                budget++;
                if (!acc && budget > 40) timeout = 1'b1;
            end
            if (timeout) break;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
    endtask

    task automatic wait_idle(output bit timeout);
        timeout = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge wr_clk);
            if (!busy) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic check_frame(input string tag, input int base);
        check({tag, "_len"}, wr_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < wr_q.size())
                check($sformatf("%s_b%0d", tag, i), wr_q[base + i], exp_q[i]);
        end
    endtask

    task automatic run_frame(input string tag, output int waits, output int base, output int start);
        bit to1, to2;
        @(posedge wr_clk);
        #1;
        base  = wr_q.size();
        start = cyc;
        send_frame(1'b0, waits, to1);
        wait_idle(to2);
        check({tag, "_timeout"}, {30'd0, to1, to2}, 32'd0);
    endtask

    int  waits, base, start, b2b0;
    bit  to1, to2;

    initial begin
        rst       = 1'b1;
        s_valid   = 1'b0;
        s_data    = 8'h00;
        s_last    = 1'b0;
        fifo_full = 1'b0;
        repeat (3) @(posedge wr_clk);
        #1;
        check("rst_s_ready",   s_ready,    0);
        check("rst_wr_en",     fifo_wr_en, 0);
        check("rst_data",      fifo_data,  0);
        check("rst_frame_cnt", frame_cnt,  0);
        check("rst_busy",      busy,       0);
        rst = 1'b0;

        // Plain 3-byte frame: checksum 11^22^33 = 00.
        pay   = '{8'h11, 8'h22, 8'h33};
        exp_q = '{8'h7E, 8'h11, 8'h22, 8'h33, 8'h00, 8'h7E};
        b2b0  = b2b;
        run_frame("s1", waits, base, start);
        check_frame("s1", base);
        check("s1_cnt", frame_cnt, 1);
        check("s1_sof_latency", wr_cyc_q[base], start + 1);
`ifndef FIFO_WR_GUARD_EN
        check("s1_last_cycle", wr_cyc_q[wr_cyc_q.size() - 1], start + 6);
        check("s1_b2b", b2b - b2b0, 5);
        check("s1_waits", waits, 2);
`endif

        // Stuffed payload byte: 7E -> 7D 5E; s_ready stays low during ESC2.
        pay   = '{8'h7E, 8'h01};
        exp_q = '{8'h7E, 8'h7D, 8'h5E, 8'h01, 8'h7F, 8'h7E};
        run_frame("s2", waits, base, start);
        check_frame("s2", base);
        check("s2_cnt", frame_cnt, 2);
`ifndef FIFO_WR_GUARD_EN
        check("s2_waits", waits, 3);
`endif

        // Single 7D byte: payload and checksum both stuffed.
        pay   = '{8'h7D};
        exp_q = '{8'h7E, 8'h7D, 8'h5D, 8'h7D, 8'h5D, 8'h7E};
        run_frame("s3", waits, base, start);
        check_frame("s3", base);
        check("s3_cnt", frame_cnt, 3);

        // Five-cycle full stall mid-payload; 2-bit counter wraps 3 -> 0 on this frame.
        pay   = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_q = '{8'h7E, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 8'h7E};
        @(posedge wr_clk);
        #1;
        base  = wr_q.size();
        start = cyc;
        b2b0  = stall_viol;
        fork
            send_frame(1'b0, waits, to1);
            begin
                repeat (2) @(posedge wr_clk);
                #1;
                fifo_full = 1'b1;
                repeat (5) @(posedge wr_clk);
                #1;
                fifo_full = 1'b0;
            end
        join
        wait_idle(to2);
        check("stall_timeout", {30'd0, to1, to2}, 32'd0);
        check_frame("stall", base);
        check("stall_viol", stall_viol - b2b0, 0);
        check("stall_cnt_wrap", frame_cnt, 0);
`ifndef FIFO_WR_GUARD_EN
        check("stall_waits", waits, 7);
        check("stall_span", wr_cyc_q[wr_cyc_q.size() - 1] - wr_cyc_q[base], 11);
`endif

        pay   = '{8'h55};
        exp_q = '{8'h7E, 8'h55, 8'h55, 8'h7E};
        run_frame("s5", waits, base, start);
        check_frame("s5", base);
        check("s5_cnt", frame_cnt, 1);

        // Partial frame then reset: outputs return to reset values immediately.
        pay = '{8'hAA, 8'hBB};
        @(posedge wr_clk);
        #1;
        send_frame(1'b1, waits, to1);
        check("rp_timeout", to1, 0);
        check("rp_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        check("rp_s_ready",   s_ready,    0);
        check("rp_wr_en",     fifo_wr_en, 0);
        check("rp_data",      fifo_data,  0);
        check("rp_frame_cnt", frame_cnt,  0);
        check("rp_busy",      busy,       0);
        @(posedge wr_clk);
        #1;
        rst = 1'b0;

        // Fresh checksum after reset: 01^02 = 03 (stale AA^BB would give 11^...).
        pay   = '{8'h01, 8'h02};
        exp_q = '{8'h7E, 8'h01, 8'h02, 8'h03, 8'h7E};
        run_frame("s6", waits, base, start);
        check_frame("s6", base);
        check("s6_cnt", frame_cnt, 1);

`ifdef FIFO_WR_GUARD_EN
        check("guard_b2b_total", b2b, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
